sram_req_arbiter: RTL and testbench

Two-master arbiter that shares one SRAM-like memory port between the IF stage's instruction fetch interface and the MEM stage's data interface. It applies data-first priority with a starvation guard for fetch, and tracks up to OUTSTANDING accepted-but-unanswered transactions in an in-order ID FIFO. Each `data_ok`/`rdata` response is steered to the master that issued the request. It sits between the CPU core and the AXI bridge / memory model.

---
 rtl/sram_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between instruction fetch
// and data masters, routing in-order responses back to the issuing master.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   inst_sram_*           fetch master (read-only): req/size/addr in,
//                         addr_ok/data_ok/rdata out
//   data_sram_*           load/store master: req/wr/size/wstrb/addr/wdata in,
//                         addr_ok/data_ok/rdata out
//   mem_*                 downstream port: req/wr/size/wstrb/addr/wdata out,
//                         addr_ok/data_ok/rdata in
//
// Data requests win by default; after STARVE_LIMIT consecutive data wins over
// a waiting fetch, the fetch is granted. Each accepted request pushes a 1-bit
// ID (0=inst, 1=data) into an in-order FIFO that steers the matching response.

module sram_req_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] FULL_CNT   = (PW + 1)'(OUTSTANDING);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INST,
        GNT_DATA
    } grant_t;

    grant_t grant;

    logic [OUTSTANDING-1:0] id_fifo;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic [3:0]             starve_cnt;

    logic full;
    logic push;
    logic pop;
    logic head;

    // Full blocks the grant even when a pop lands in the same cycle, so the
    // next request after a full FIFO is granted one cycle after the first pop.
    assign full = (count == FULL_CNT);

    always_comb begin
        grant = GNT_NONE;
        if (reset || full) begin
            grant = GNT_NONE;
        end else if (inst_sram_req && data_sram_req) begin
            grant = (starve_cnt == STARVE_MAX) ? GNT_INST : GNT_DATA;
        end else if (data_sram_req) begin
            grant = GNT_DATA;
        end else if (inst_sram_req) begin
            grant = GNT_INST;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        unique case (grant)
            GNT_INST: begin
                mem_req  = 1'b1;
                mem_size = inst_sram_size;
                mem_addr = inst_sram_addr;
            end
            GNT_DATA: begin
                mem_req   = 1'b1;
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign inst_sram_addr_ok = mem_addr_ok && (grant == GNT_INST);
    assign data_sram_addr_ok = mem_addr_ok && (grant == GNT_DATA);

    assign push = mem_req && mem_addr_ok;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign pop  = mem_data_ok && (count != '0);
    assign head = id_fifo[rd_ptr];

    assign inst_sram_data_ok = pop && !head;
    assign data_sram_data_ok = pop && head;
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= (grant == GNT_DATA);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counts data wins while a fetch is waiting; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!inst_sram_req) begin
            starve_cnt <= 4'd0;
        end else if (push && grant == GNT_INST) begin
            starve_cnt <= 4'd0;
        end else if (push && grant == GNT_DATA && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed self-checking bench for sram_req_arbiter.
// Inputs change on the falling edge; outputs are sampled 1ns later.

module tb_sram_req_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    sram_req_arbiter #(
        .OUTSTANDING (4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .mem_req          (mem_req),
        .mem_wr           (mem_wr),
        .mem_size         (mem_size),
        .mem_wstrb        (mem_wstrb),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_addr_ok      (mem_addr_ok),
        .mem_data_ok      (mem_data_ok),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        inst_sram_req   = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_addr  = 32'd0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'd0;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        mem_addr_ok     = 1'b0;
        mem_data_ok     = 1'b0;
        mem_rdata       = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        mem_data_ok   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_req got %b exp 0", mem_req);
        end
        checks++;
        if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin
            errors++;
            $display("FAIL reset_addr_ok got %b%b exp 00",
                     inst_sram_addr_ok, data_sram_addr_ok);
        end
        checks++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL reset_data_ok got %b%b exp 00",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        checks++;
        if (dut.count !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", dut.count);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0000;
        mem_addr_ok    = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1c00_0000 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req got req=%b addr=%h wr=%b exp 1 1c000000 0",
                     mem_req, mem_addr, mem_wr);
        end
        checks++;
        if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr_ok got i=%b d=%b exp 1 0",
                     inst_sram_addr_ok, data_sram_addr_ok);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0c0c;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data_ok got i=%b d=%b exp 1 0",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        checks++;
        if (inst_sram_rdata !== 32'h0280_0c0c) begin
            errors++;
            $display("FAIL fetch_rdata got %h exp 02800c0c", inst_sram_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.count !== '0) begin
            errors++;
            $display("FAIL fetch_count got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_contention();
        bit prev_inst;
        bit exp_inst;
        prev_inst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inst_sram_req  = 1'b1;
            inst_sram_addr = 32'h0000_4000 + 32'(i * 4);
            data_sram_req  = 1'b1;
            data_sram_addr = 32'h0000_8000 + 32'(i * 4);
            mem_addr_ok    = 1'b1;
            mem_data_ok    = (i > 0);
            mem_rdata      = 32'hA000_0000 + 32'(i);
            exp_inst       = (i % 4 == 3);
            #1;
            checks++;
            if (inst_sram_addr_ok !== exp_inst || data_sram_addr_ok !== !exp_inst) begin
                errors++;
                $display("FAIL contention_grant cyc %0d got i=%b d=%b exp i=%b",
                         i, inst_sram_addr_ok, data_sram_addr_ok, exp_inst);
            end
            if (i > 0) begin
                checks++;
                if (inst_sram_data_ok !== prev_inst || data_sram_data_ok !== !prev_inst) begin
                    errors++;
                    $display("FAIL contention_route cyc %0d got i=%b d=%b exp i=%b",
                             i, inst_sram_data_ok, data_sram_data_ok, prev_inst);
                end
            end
            prev_inst = exp_inst;
        end
        @(negedge clk);
        idle_inputs();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hA000_0008;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0
            || inst_sram_rdata !== 32'hA000_0008) begin
            errors++;
            $display("FAIL contention_last got i=%b d=%b rdata=%h exp 1 0 a0000008",
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.count !== '0) begin
            errors++;
            $display("FAIL contention_count got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_sram_req  = 1'b1;
            inst_sram_addr = 32'h0000_2000 + 32'(i * 4);
            mem_addr_ok    = 1'b1;
            #1;
            checks++;
            if (inst_sram_addr_ok !== 1'b1) begin
                errors++;
                $display("FAIL full_fill cyc %0d got %b exp 1", i, inst_sram_addr_ok);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL full_block got req=%b aok=%b exp 0 0",
                     mem_req, inst_sram_addr_ok);
        end
        @(negedge clk);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_0000;
        #1;
        checks++;
        if (mem_req !== 1'b0 || inst_sram_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_same got req=%b dok=%b exp 0 1",
                     mem_req, inst_sram_data_ok);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || inst_sram_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_resume got req=%b aok=%b exp 1 1",
                     mem_req, inst_sram_addr_ok);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            mem_data_ok = 1'b1;
            mem_rdata   = 32'h5555_0001 + 32'(i);
            #1;
            checks++;
            if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h5555_0001 + 32'(i)) begin
                errors++;
                $display("FAIL full_drain %0d got dok=%b rdata=%h exp 1 %h",
                         i, inst_sram_data_ok, inst_sram_rdata, 32'h5555_0001 + 32'(i));
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.count !== '0) begin
            errors++;
            $display("FAIL full_count got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_mixed();
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h0000_0100;
        mem_addr_ok    = 1'b1;
        #1;
        checks++;
        if (inst_sram_addr_ok !== 1'b1 || mem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL mixed_i0 got aok=%b addr=%h exp 1 00000100",
                     inst_sram_addr_ok, mem_addr);
        end
        @(negedge clk);
        inst_sram_req   = 1'b0;
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_wstrb = 4'hF;
        data_sram_addr  = 32'h0000_0200;
        data_sram_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF
            || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mixed_store got aok=%b wr=%b strb=%h addr=%h wdata=%h",
                     data_sram_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata);
        end
        @(negedge clk);
        idle_inputs();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h0000_0104;
        data_sram_wdata = 32'h1234_5678;
        data_sram_wstrb = 4'hF;
        data_sram_wr    = 1'b1;
        mem_addr_ok    = 1'b1;
        #1;
        checks++;
        if (inst_sram_addr_ok !== 1'b1 || mem_wr !== 1'b0 || mem_wstrb !== 4'h0
            || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL mixed_i1 got aok=%b wr=%b strb=%h wdata=%h exp 1 0 0 0",
                     inst_sram_addr_ok, mem_wr, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        idle_inputs();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0
            || inst_sram_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL mixed_r0 got i=%b d=%b rdata=%h exp 1 0 11111111",
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        @(negedge clk);
        mem_rdata = 32'h2222_2222;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL mixed_r1 got i=%b d=%b exp 0 1",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        @(negedge clk);
        mem_rdata = 32'h3333_3333;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0
            || inst_sram_rdata !== 32'h3333_3333) begin
            errors++;
            $display("FAIL mixed_r2 got i=%b d=%b rdata=%h exp 1 0 33333333",
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_sram_req  = 1'b1;
            inst_sram_addr = 32'h0000_3000 + 32'(i * 4);
            mem_addr_ok    = 1'b1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.count !== 3'd3 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got count=%0d req=%b exp 3 1", dut.count, mem_req);
        end
        mem_data_ok = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (dut.count !== '0 || mem_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL areset_now got count=%0d req=%b aok=%b exp 0 0 0",
                     dut.count, mem_req, inst_sram_addr_ok);
        end
        checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL areset_dok got i=%b d=%b exp 0 0",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        @(negedge clk);
        idle_inputs();
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL areset_stray got i=%b d=%b exp 0 0",
                     inst_sram_data_ok, data_sram_data_ok);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.count !== '0) begin
            errors++;
            $display("FAIL areset_count got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_wrap();
        int due[$];
        bit iss[$];
        int idq[$];
        int n_iss;
        int n_resp;
        int cyc;
        int last_due;
        int d;
        bit issue;
        bit is_data;
        bit resp;
        bit r_data;
        int r_id;
        n_iss    = 0;
        n_resp   = 0;
        cyc      = 0;
        last_due = -1;
        while (n_resp < 20 && cyc < 300) begin
            @(negedge clk);
            idle_inputs();
            mem_addr_ok = 1'b1;
            issue   = (n_iss < 20) && ((n_iss - n_resp) < 4);
            is_data = n_iss[0];
            if (issue) begin
                if (is_data) begin
                    data_sram_req  = 1'b1;
                    data_sram_addr = 32'h0000_1000 + 32'(n_iss * 4);
                end else begin
                    inst_sram_req  = 1'b1;
                    inst_sram_addr = 32'h0000_1000 + 32'(n_iss * 4);
                end
            end
            resp   = (due.size() > 0) && (due[0] <= cyc);
            r_data = 1'b0;
            r_id   = 0;
            if (resp) begin
                r_data      = iss[0];
                r_id        = idq[0];
                mem_data_ok = 1'b1;
                mem_rdata   = 32'hC000_0000 + 32'(r_id);
            end
            #1;
            if (issue) begin
                checks++;
                if (inst_sram_addr_ok !== !is_data || data_sram_addr_ok !== is_data
                    || mem_addr !== 32'h0000_1000 + 32'(n_iss * 4)) begin
                    errors++;
                    $display("FAIL wrap_issue %0d got i=%b d=%b addr=%h",
                             n_iss, inst_sram_addr_ok, data_sram_addr_ok, mem_addr);
                end
            end
            checks++;
            if (inst_sram_data_ok !== (resp && !r_data)
                || data_sram_data_ok !== (resp && r_data)) begin
                errors++;
                $display("FAIL wrap_route cyc %0d got i=%b d=%b exp resp=%b data=%b",
                         cyc, inst_sram_data_ok, data_sram_data_ok, resp, r_data);
            end
            if (resp) begin
                checks++;
                if ((r_data ? data_sram_rdata : inst_sram_rdata) !== 32'hC000_0000 + 32'(r_id)) begin
                    errors++;
                    $display("FAIL wrap_rdata id %0d got i=%h d=%h",
                             r_id, inst_sram_rdata, data_sram_rdata);
                end
                void'(due.pop_front());
                void'(iss.pop_front());
                void'(idq.pop_front());
                n_resp++;
            end
            if (issue) begin
                d = cyc + int'($urandom_range(1, 5));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                due.push_back(d);
                iss.push_back(is_data);
                idq.push_back(n_iss);
                n_iss++;
            end
            cyc++;
        end
        checks++;
        if (n_resp != 20) begin
            errors++;
            $display("FAIL wrap_timeout got %0d responses exp 20", n_resp);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.count !== '0 || dut.wr_ptr !== dut.rd_ptr) begin
            errors++;
            $display("FAIL wrap_end got count=%0d wr=%0d rd=%0d exp 0 equal",
                     dut.count, dut.wr_ptr, dut.rd_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_full();
        test_mixed();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
